// File: rtl/regfile_pkg.sv
// Shared defaults and types for the one-hot-write register file.
// The highest register index is the hardwired zero register.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int ZERO_REG = NUM_REGS - 1;

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/regfile_onehot_wr_if.sv
// Write/read bus of the register file: decoded write enables, write data,
// two read ports and the sticky malformed-enable flag.
interface regfile_onehot_wr_if
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W
);

  logic [NUM_REGS-1:0] wr_onehot;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   rd_addr1;
  logic [ADDR_W-1:0]   rd_addr2;
  logic [DATA_W-1:0]   rd_data1;
  logic [DATA_W-1:0]   rd_data2;
  logic                onehot_err;

  modport master (
    output wr_onehot, wr_data, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, onehot_err
  );

  modport slave (
    input  wr_onehot, wr_data, rd_addr1, rd_addr2,
    output rd_data1, rd_data2, onehot_err
  );

endinterface

// File: rtl/regfile_onehot_wr_reg_word.sv
// reg_word: one register of the file, loaded when en is high,
// cleared asynchronously by an active-high reset.
module reg_word #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_r;

  // Storage flop with load enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= '0;
    end else if (en) begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/regfile_onehot_wr.sv
// Register file written through a one-hot enable vector, with two
// combinational read ports. Optional write-through bypass: REGFILE_BYPASS_EN.
module regfile_onehot_wr
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  regfile_onehot_wr_if.slave bus
);

  localparam int ZERO_IDX = NUM_REGS - 1;
  localparam logic [ADDR_W:0] ZERO_ADDR = ZERO_IDX[ADDR_W:0];

  logic [NUM_REGS-1:0]             onehot_m1_s;
  logic                            multi_s;
  logic                            single_s;
  logic [NUM_REGS-1:0]             wr_en_s;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_s;
  logic                            err_r;
  logic [DATA_W-1:0]               rd_data1_s;
  logic [DATA_W-1:0]               rd_data2_s;

  // v & (v-1) is nonzero exactly when two or more bits are set.
  assign onehot_m1_s = bus.wr_onehot - {{(NUM_REGS-1){1'b0}}, 1'b1};
  assign multi_s     = |(bus.wr_onehot & onehot_m1_s);
  assign single_s    = (|bus.wr_onehot) & ~multi_s;
  assign wr_en_s     = bus.wr_onehot & {NUM_REGS{~multi_s}};

  for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_word
    reg_word #(.DATA_W(DATA_W)) u_word (
      .clk   (clk),
      .reset (reset),
      .en    (wr_en_s[i]),
      .d     (bus.wr_data),
      .q     (regs_s[i])
    );
  end

  assign regs_s[ZERO_IDX] = '0;

  // Sticky flag for a malformed enable vector; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (multi_s) begin
      err_r <= 1'b1;
    end
  end

  // Read muxes; the zero register and out-of-range indices read as zero.
  always_comb begin
    rd_data1_s = '0;
    rd_data2_s = '0;
    if ({1'b0, bus.rd_addr1} < ZERO_ADDR) begin
`ifdef REGFILE_BYPASS_EN
      if (single_s && bus.wr_onehot[bus.rd_addr1]) begin
        rd_data1_s = bus.wr_data;
      end else begin
        rd_data1_s = regs_s[bus.rd_addr1];
      end
`else
      rd_data1_s = regs_s[bus.rd_addr1];
`endif
    end else begin
      rd_data1_s = '0;
    end
    if ({1'b0, bus.rd_addr2} < ZERO_ADDR) begin
`ifdef REGFILE_BYPASS_EN
      if (single_s && bus.wr_onehot[bus.rd_addr2]) begin
        rd_data2_s = bus.wr_data;
      end else begin
        rd_data2_s = regs_s[bus.rd_addr2];
      end
`else
      rd_data2_s = regs_s[bus.rd_addr2];
`endif
    end else begin
      rd_data2_s = '0;
    end
  end

  assign bus.rd_data1   = rd_data1_s;
  assign bus.rd_data2   = rd_data2_s;
  assign bus.onehot_err = err_r;

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Self-checking bench for regfile_onehot_wr against a behavioural array model.
// Build with REGFILE_BYPASS_EN defined to check the write-through variant.
module tb_regfile_onehot_wr;
  import regfile_pkg::*;

  logic clk;
  logic reset;

  regfile_onehot_wr_if bus ();

  regfile_onehot_wr dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] model [NUM_REGS];
  logic              model_err;
  int                n_checks;
  int                n_fail;

  function automatic void model_clear();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    model_err = 1'b0;
  endfunction

  // Expected read value from the model and the current bus inputs.
  function automatic logic [DATA_W-1:0] exp_rd(input int a);
    if (a >= NUM_REGS - 1) return '0;
`ifdef REGFILE_BYPASS_EN
    if ($countones(bus.wr_onehot) == 1 && bus.wr_onehot[a]) return bus.wr_data;
`endif
    return model[a];
  endfunction

  // One rising edge, updating the model from the inputs applied at that edge.
  task automatic step();
    int cnt;
    @(posedge clk);
    if (!reset) begin
      cnt = $countones(bus.wr_onehot);
      if (cnt > 1) model_err = 1'b1;
      if (cnt == 1) begin
        for (int i = 0; i < NUM_REGS - 1; i++)
          if (bus.wr_onehot[i]) model[i] = bus.wr_data;
      end
    end
    #1;
  endtask

  task automatic write_reg(input int idx, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bus.wr_onehot = '0;
    bus.wr_onehot[idx] = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_onehot = '0;
  endtask

  task automatic test_reset();
    bus.wr_onehot = '0;
    bus.wr_data   = '0;
    bus.rd_addr1  = '0;
    bus.rd_addr2  = '0;
    reset = 1'b1;
    model_clear();
    #12;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) write_reg(i * 3, 64'(i + 1) * 64'h1111_0000_0000_0101);
    @(negedge clk);
    bus.wr_onehot = 32'h0000_0003;
    step();
    bus.wr_onehot = '0;
    if (bus.onehot_err !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_preload_err: got %b want 1", bus.onehot_err);
    end
    n_checks++;
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    if (bus.onehot_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got %b want 0", bus.onehot_err);
    end
    n_checks++;
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.rd_addr1 = ADDR_W'(i);
      bus.rd_addr2 = ADDR_W'(NUM_REGS - 1 - i);
      #1;
      if (bus.rd_data1 !== 64'h0 || bus.rd_data2 !== 64'h0) begin
        n_fail++;
        $display("FAIL reset_regs[%0d]: got %h/%h want 0", i, bus.rd_data1, bus.rd_data2);
      end
      n_checks++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_write();
    write_reg(3, 64'hDEAD_BEEF_0000_0003);
    bus.rd_addr1 = 5'd3;
    bus.rd_addr2 = 5'd4;
    #1;
    if (bus.rd_data1 !== 64'hDEAD_BEEF_0000_0003) begin
      n_fail++;
      $display("FAIL basic_rd3: got %h want %h", bus.rd_data1, 64'hDEAD_BEEF_0000_0003);
    end
    n_checks++;
    if (bus.rd_data2 !== 64'h0) begin
      n_fail++;
      $display("FAIL basic_rd4: got %h want 0", bus.rd_data2);
    end
    n_checks++;
    bus.rd_addr2 = 5'd3;
    #1;
    if (bus.rd_data2 !== bus.rd_data1 || bus.rd_data2 !== 64'hDEAD_BEEF_0000_0003) begin
      n_fail++;
      $display("FAIL same_addr: got %h want %h", bus.rd_data2, 64'hDEAD_BEEF_0000_0003);
    end
    n_checks++;
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    bus.wr_onehot = 32'h8000_0000;
    bus.wr_data   = '1;
    bus.rd_addr1  = 5'd31;
    #1;
    if (bus.rd_data1 !== 64'h0) begin
      n_fail++;
      $display("FAIL zero_pre: got %h want 0", bus.rd_data1);
    end
    n_checks++;
    step();
    bus.wr_onehot = '0;
    #1;
    if (bus.rd_data1 !== 64'h0) begin
      n_fail++;
      $display("FAIL zero_rd31: got %h want 0", bus.rd_data1);
    end
    n_checks++;
    if (bus.onehot_err !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_err: got %b want 0", bus.onehot_err);
    end
    n_checks++;
  endtask

  task automatic test_illegal();
    write_reg(5, 64'h1234);
    @(negedge clk);
    bus.wr_onehot = 32'h0000_0060;
    bus.wr_data   = 64'hFFFF;
    step();
    bus.wr_onehot = '0;
    bus.rd_addr1 = 5'd5;
    bus.rd_addr2 = 5'd6;
    #1;
    if (bus.rd_data1 !== 64'h1234 || bus.rd_data2 !== 64'h0) begin
      n_fail++;
      $display("FAIL illegal_regs: got %h/%h want 1234/0", bus.rd_data1, bus.rd_data2);
    end
    n_checks++;
    if (bus.onehot_err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_err: got %b want 1", bus.onehot_err);
    end
    n_checks++;
    for (int i = 0; i < 10; i++) begin
      write_reg(i + 10, 64'(i) + 64'h100);
      if (bus.onehot_err !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_sticky[%0d]: got %b want 1", i, bus.onehot_err);
      end
      n_checks++;
    end
    bus.rd_addr1 = 5'd19;
    #1;
    if (bus.rd_data1 !== 64'h109) begin
      n_fail++;
      $display("FAIL legal_after_err: got %h want 109", bus.rd_data1);
    end
    n_checks++;
    #1;
    reset = 1'b1;
    model_clear();
    #1;
    if (bus.onehot_err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_clear: got %b want 0", bus.onehot_err);
    end
    n_checks++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] want;
    write_reg(7, 64'h5555);
    @(negedge clk);
    bus.wr_onehot = 32'h0000_0080;
    bus.wr_data   = 64'hAAAA;
    bus.rd_addr1  = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    want = 64'hAAAA;
`else
    want = 64'h5555;
`endif
    if (bus.rd_data1 !== want) begin
      n_fail++;
      $display("FAIL bypass_pre: got %h want %h", bus.rd_data1, want);
    end
    n_checks++;
    step();
    bus.wr_onehot = '0;
    #1;
    if (bus.rd_data1 !== 64'hAAAA) begin
      n_fail++;
      $display("FAIL bypass_post: got %h want AAAA", bus.rd_data1);
    end
    n_checks++;
    // Illegal vector touching reg 7 must never forward.
    @(negedge clk);
    bus.wr_onehot = 32'h0000_0180;
    bus.wr_data   = 64'hBBBB;
    #1;
    if (bus.rd_data1 !== 64'hAAAA) begin
      n_fail++;
      $display("FAIL bypass_illegal: got %h want AAAA", bus.rd_data1);
    end
    n_checks++;
    bus.wr_onehot = '0;
  endtask

  task automatic test_reset_midwrite();
    @(negedge clk);
    bus.wr_onehot = 32'h0000_0001;
    bus.wr_data   = 64'hC0DE;
    #2;
    reset = 1'b1;
    model_clear();
    step();
    bus.wr_onehot = '0;
    bus.rd_addr1  = 5'd0;
    #1;
    if (bus.rd_data1 !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mid_lost: got %h want 0", bus.rd_data1);
    end
    n_checks++;
    reset = 1'b0;
    write_reg(0, 64'hF00D);
    #1;
    if (bus.rd_data1 !== 64'hF00D) begin
      n_fail++;
      $display("FAIL reset_first_write: got %h want F00D", bus.rd_data1);
    end
    n_checks++;
  endtask

  task automatic test_random();
    int r;
    int b0;
    int b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      bus.wr_onehot = '0;
      if (r < 55) begin
        bus.wr_onehot[$urandom_range(0, NUM_REGS - 2)] = 1'b1;
      end else if (r < 70) begin
        bus.wr_onehot = '0;
      end else if (r < 80) begin
        bus.wr_onehot[NUM_REGS - 1] = 1'b1;
      end else if (r < 97 || n < 150) begin
        bus.wr_onehot[$urandom_range(0, NUM_REGS - 2)] = 1'b1;
      end else begin
        b0 = $urandom_range(0, NUM_REGS - 1);
        b1 = (b0 + $urandom_range(1, NUM_REGS - 1)) % NUM_REGS;
        bus.wr_onehot[b0] = 1'b1;
        bus.wr_onehot[b1] = 1'b1;
      end
      bus.wr_data  = {$urandom, $urandom};
      bus.rd_addr1 = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      bus.rd_addr2 = ADDR_W'($urandom_range(0, NUM_REGS - 1));
      #1;
      if (bus.rd_data1 !== exp_rd(int'(bus.rd_addr1))) begin
        n_fail++;
        $display("FAIL rand_rd1[%0d]: got %h want %h", n, bus.rd_data1, exp_rd(int'(bus.rd_addr1)));
      end
      n_checks++;
      if (bus.rd_data2 !== exp_rd(int'(bus.rd_addr2))) begin
        n_fail++;
        $display("FAIL rand_rd2[%0d]: got %h want %h", n, bus.rd_data2, exp_rd(int'(bus.rd_addr2)));
      end
      n_checks++;
      step();
      if (bus.onehot_err !== model_err) begin
        n_fail++;
        $display("FAIL rand_err[%0d]: got %b want %b", n, bus.onehot_err, model_err);
      end
      n_checks++;
    end
    bus.wr_onehot = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    test_reset();
    test_basic_write();
    test_zero_reg();
    test_illegal();
    test_bypass();
    test_reset_midwrite();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
